// File: rtl/act_pkg.sv
// Shared constants for the piecewise-quadratic activation unit: coefficients,
// breakpoints, FSM state and mode encodings.
package act_pkg;

  localparam int COEF_FRAC = 11;

  localparam int BP_NEG6 = -6;
  localparam int BP_NEG3 = -3;
  localparam int BP_ZERO = 0;
  localparam int BP_POS3 = 3;
  localparam int BP_POS6 = 6;

  // Q.11 coefficients, named by the lower breakpoint of their interval
  localparam int P0_N6 = 416;
  localparam int P1_N6 = 147;
  localparam int P2_N6 = 13;
  localparam int P0_N3 = 1028;
  localparam int P1_N3 = 558;
  localparam int P2_N3 = 83;
  localparam int P0_Z  = 1020;
  localparam int P1_Z  = 558;
  localparam int P2_Z  = -83;
  localparam int P0_P3 = 1632;
  localparam int P1_P3 = 147;
  localparam int P2_P3 = -13;

  typedef enum logic [2:0] {IDLE, SEL, MAC1, MAC2, DONE} state_t;
  typedef enum logic {MODE_SIGMOID = 1'b0, MODE_TANH = 1'b1} mode_t;

endpackage

// File: rtl/act_interval_sel.sv
// Maps the (possibly doubled) operand x' onto its interval's {p2, p1, p0},
// with coefficients rescaled from Q.11 to Q.QM.
module act_interval_sel #(
  parameter int QN = 6,
  parameter int QM = 11
) (
  input  logic signed [QN+QM:0] xp,
  output logic signed [QN+QM:0] p2,
  output logic signed [QN+QM:0] p1,
  output logic signed [QN+QM:0] p0
);
  import act_pkg::*;

  localparam int W = QN + QM + 1;

  function automatic logic signed [W-1:0] coef(input int c);
    return W'(c) <<< (QM - COEF_FRAC);
  endfunction

  function automatic logic signed [W-1:0] bp(input int b);
    return W'(b) <<< QM;
  endfunction

  // Outer intervals use zero slope so the same two MAC steps yield 0 or 1.0
  always_comb begin
    p2 = '0;
    p1 = '0;
    p0 = '0;
    if (xp < bp(BP_NEG6)) begin
      p0 = '0;
    end else if (xp < bp(BP_NEG3)) begin
      p2 = coef(P2_N6); p1 = coef(P1_N6); p0 = coef(P0_N6);
    end else if (xp < bp(BP_ZERO)) begin
      p2 = coef(P2_N3); p1 = coef(P1_N3); p0 = coef(P0_N3);
    end else if (xp < bp(BP_POS3)) begin
      p2 = coef(P2_Z); p1 = coef(P1_Z); p0 = coef(P0_Z);
    end else if (xp < bp(BP_POS6)) begin
      p2 = coef(P2_P3); p1 = coef(P1_P3); p0 = coef(P0_P3);
    end else begin
      p0 = coef(1 << COEF_FRAC);
    end
  end

endmodule

// File: rtl/act_pwq_unit.sv
// Piecewise-quadratic sigmoid/tanh evaluator with one shared multiplier.
// Define ACT_TANH_EN to honour the mode input (tanh); otherwise always sigmoid.
module act_pwq_unit #(
  parameter int QN = 6,
  parameter int QM = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [QN+QM:0]  operand,
  input  logic            mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [QN+QM:0]  result
);
  import act_pkg::*;

  localparam int W = QN + QM + 1;
  localparam logic signed [W+1:0] MAX_W = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MIN_W = {3'b111, {(W-1){1'b0}}};

  if (QN < 3) begin : g_qn_chk
    $error("act_pwq_unit: QN must be >= 3");
  end
  if (QM < 11) begin : g_qm_chk
    $error("act_pwq_unit: QM must be >= 11");
  end

  function automatic logic signed [W-1:0] sat_w(input logic signed [W+1:0] v);
    if (v > MAX_W) return MAX_W[W-1:0];
    if (v < MIN_W) return MIN_W[W-1:0];
    return v[W-1:0];
  endfunction

  state_t state, state_nxt;
  logic signed [W-1:0]   x_q, xp, t_q, result_q;
  logic signed [W-1:0]   p2_c, p1_c, p0_c, p2_q, p1_q, p0_q;
  logic signed [W-1:0]   mul_a, addend, mac_sat, y_final;
  logic signed [2*W-1:0] prod, shifted;
  logic signed [W:0]     sum;

`ifdef ACT_TANH_EN
  mode_t mode_q;
  logic signed [W+1:0] post;

  always_comb begin
    xp = x_q;
    if (mode_q == MODE_TANH) xp = sat_w({x_q[W-1], x_q, 1'b0});
  end

  // tanh(x) = 2*sigmoid(2x) - 1
  assign post = {mac_sat[W-1], mac_sat, 1'b0} - ((W+2)'(1) <<< QM);
  assign y_final = (mode_q == MODE_TANH) ? sat_w(post) : mac_sat;
`else
  logic mode_unused;
  assign mode_unused = mode;
  assign xp = x_q;
  assign y_final = mac_sat;
`endif

  act_interval_sel #(.QN(QN), .QM(QM)) u_sel (
    .xp (xp),
    .p2 (p2_c),
    .p1 (p1_c),
    .p0 (p0_c)
  );

  // Shared multiplier: p2*x' in MAC1, t*x' in MAC2
  assign mul_a   = (state == MAC1) ? p2_q : t_q;
  assign addend  = (state == MAC1) ? p1_q : p0_q;
  assign prod    = mul_a * xp;
  assign shifted = prod >>> QM;
  assign sum     = shifted[W:0] + {addend[W-1], addend};
  assign mac_sat = sat_w({sum[W], sum});

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid) state_nxt = SEL;
      end
      SEL:  state_nxt = MAC1;
      MAC1: state_nxt = MAC2;
      MAC2: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x_q      <= '0;
      p2_q     <= '0;
      p1_q     <= '0;
      p0_q     <= '0;
      t_q      <= '0;
      result_q <= '0;
`ifdef ACT_TANH_EN
      mode_q   <= MODE_SIGMOID;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          x_q    <= operand;
`ifdef ACT_TANH_EN
          mode_q <= mode_t'(mode);
`endif
        end
        SEL: begin
          p2_q <= p2_c;
          p1_q <= p1_c;
          p0_q <= p0_c;
        end
        MAC1: t_q <= mac_sat;
        MAC2: result_q <= y_final;
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
